// File: rtl/vga_timing_gen.sv
// VGA/SVGA timing generator: free-running H/V counters
// with registered sync, data-enable, coordinates and strobes.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 1024,
  parameter int unsigned H_FP     = 24,
  parameter int unsigned H_SYNC   = 136,
  parameter int unsigned H_BP     = 160,
  parameter int unsigned V_ACTIVE = 768,
  parameter int unsigned V_FP     = 3,
  parameter int unsigned V_SYNC   = 6,
  parameter int unsigned V_BP     = 29,
  parameter bit          H_POL    = 1'b0,
  parameter bit          V_POL    = 1'b0,
  parameter int unsigned CW       = 11
) (
  input  logic          clk_vga,
  input  logic          rst,
  input  logic          ce,
  output logic          hs,
  output logic          vs,
  output logic          de,
  output logic [CW-1:0] hc_visible,
  output logic [CW-1:0] vc_visible,
  output logic          line_start,
  output logic          frame_start
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_SY   = CW'(H_SYNC);
  localparam logic [CW-1:0] V_SY   = CW'(V_SYNC);
  localparam logic [CW-1:0] H_A0   = CW'(H_SYNC + H_BP);
  localparam logic [CW-1:0] V_A0   = CW'(V_SYNC + V_BP);
  // Last active position; avoids needing CW to hold H_TOTAL when FP=0.
  localparam logic [CW-1:0] H_A1   = CW'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [CW-1:0] V_A1   = CW'(V_SYNC + V_BP + V_ACTIVE - 1);

  logic [CW-1:0] r_hc;
  logic [CW-1:0] r_vc;
  logic          r_hs;
  logic          r_vs;
  logic          r_de;
  logic [CW-1:0] r_hx;
  logic [CW-1:0] r_vy;
  logic          r_ls;
  logic          r_fs;

  logic          w_hs;
  logic          w_vs;
  logic          w_h_act;
  logic          w_v_act;
  logic          w_de;
  logic [CW-1:0] w_hx;
  logic [CW-1:0] w_vy;
  logic          w_h_wrap;
  logic          w_v_wrap;

  // Decode of the current (pre-increment) counter position.
  always_comb begin
    w_hs     = (r_hc < H_SY) ? H_POL : ~H_POL;
    w_vs     = (r_vc < V_SY) ? V_POL : ~V_POL;
    w_h_act  = (r_hc >= H_A0) && (r_hc <= H_A1);
    w_v_act  = (r_vc >= V_A0) && (r_vc <= V_A1);
    w_de     = w_h_act && w_v_act;
    w_hx     = w_de ? (r_hc - H_A0) : '0;
    w_vy     = w_de ? (r_vc - V_A0) : '0;
    w_h_wrap = (r_hc == H_LAST);
    w_v_wrap = (r_vc == V_LAST);
  end

  // Counters advance and outputs load the decode on each enabled edge.
  always_ff @(posedge clk_vga) begin
    if (rst) begin
      r_hc <= '0;
      r_vc <= '0;
      r_hs <= ~H_POL;
      r_vs <= ~V_POL;
      r_de <= 1'b0;
      r_hx <= '0;
      r_vy <= '0;
      r_ls <= 1'b0;
      r_fs <= 1'b0;
    end else if (ce) begin
      r_hs <= w_hs;
      r_vs <= w_vs;
      r_de <= w_de;
      r_hx <= w_hx;
      r_vy <= w_vy;
      r_ls <= (r_hc == '0);
      r_fs <= (r_hc == '0) && (r_vc == '0);
      if (w_h_wrap) begin
        r_hc <= '0;
        r_vc <= w_v_wrap ? '0 : r_vc + 1'b1;
      end else begin
        r_hc <= r_hc + 1'b1;
      end
    end else begin
      r_ls <= 1'b0;
      r_fs <= 1'b0;
    end
  end

  assign hs          = r_hs;
  assign vs          = r_vs;
  assign de          = r_de;
  assign hc_visible  = r_hx;
  assign vc_visible  = r_vy;
  assign line_start  = r_ls;
  assign frame_start = r_fs;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: small mode scoreboarded every clk,
// inverted-polarity twin and a 640x480 instance.
module tb_vga_timing_gen;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic [10:0] x;
    logic [10:0] y;
    logic        ls;
    logic        fs;
  } exp_t;

  localparam int HA = 16, HF = 2, HS = 3, HB = 4;
  localparam int VA = 6, VF = 1, VS = 2, VB = 2;
  localparam int HT = HS + HB + HA + HF;
  localparam int VT = VS + VB + VA + VF;
  localparam int FR = HT * VT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce  = 1'b0;

  logic        hs, vs, de, ls, fs;
  logic [10:0] hx, vy;
  logic        ihs, ivs, ide, ils, ifs;
  logic [10:0] ihx, ivy;
  logic        bhs, bvs, bde, bls, bfs;
  logic [10:0] bhx, bvy;

  int checks = 0;
  int errors = 0;

  int   m_hc = 0;
  int   m_vc = 0;
  exp_t m_out;
  exp_t sb[$];
  exp_t smp;
  exp_t smpi;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .H_POL(1'b0), .V_POL(1'b0), .CW(11)
  ) u_dut (
    .clk_vga(clk), .rst(rst), .ce(ce),
    .hs(hs), .vs(vs), .de(de),
    .hc_visible(hx), .vc_visible(vy),
    .line_start(ls), .frame_start(fs)
  );

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .H_POL(1'b1), .V_POL(1'b1), .CW(11)
  ) u_inv (
    .clk_vga(clk), .rst(rst), .ce(ce),
    .hs(ihs), .vs(ivs), .de(ide),
    .hc_visible(ihx), .vc_visible(ivy),
    .line_start(ils), .frame_start(ifs)
  );

  vga_timing_gen #(
    .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_ACTIVE(480), .V_FP(10), .V_SYNC(2), .V_BP(33),
    .H_POL(1'b0), .V_POL(1'b0), .CW(11)
  ) u_640 (
    .clk_vga(clk), .rst(rst), .ce(ce),
    .hs(bhs), .vs(bvs), .de(bde),
    .hc_visible(bhx), .vc_visible(bvy),
    .line_start(bls), .frame_start(bfs)
  );

  // One clk: drive, update model, push expectation, then pop and compare.
  task automatic cyc(input logic r, input logic c);
    exp_t e;
    exp_t ei;
    bit   act;
    rst = r;
    ce  = c;
    @(posedge clk);
    if (r) begin
      m_hc  = 0;
      m_vc  = 0;
      m_out = '{hs: 1'b1, vs: 1'b1, de: 1'b0, x: '0, y: '0,
                ls: 1'b0, fs: 1'b0};
    end else if (c) begin
      act      = (m_hc >= HS + HB) && (m_hc < HS + HB + HA) &&
                 (m_vc >= VS + VB) && (m_vc < VS + VB + VA);
      m_out.hs = !(m_hc < HS);
      m_out.vs = !(m_vc < VS);
      m_out.de = act;
      m_out.x  = act ? 11'(m_hc - HS - HB) : 11'd0;
      m_out.y  = act ? 11'(m_vc - VS - VB) : 11'd0;
      m_out.ls = (m_hc == 0);
      m_out.fs = (m_hc == 0) && (m_vc == 0);
      m_hc = m_hc + 1;
      if (m_hc == HT) begin
        m_hc = 0;
        m_vc = (m_vc + 1) % VT;
      end
    end else begin
      m_out.ls = 1'b0;
      m_out.fs = 1'b0;
    end
    sb.push_back(m_out);
    #1;
    e    = sb.pop_front();
    smp  = {hs, vs, de, hx, vy, ls, fs};
    smpi = {ihs, ivs, ide, ihx, ivy, ils, ifs};
    checks++;
    if (smp !== e) begin
      errors++;
      $display("FAIL sb_main got %h exp %h (hc %0d vc %0d)",
               smp, e, m_hc, m_vc);
    end
    ei    = e;
    ei.hs = ~e.hs;
    ei.vs = ~e.vs;
    checks++;
    if (smpi !== ei) begin
      errors++;
      $display("FAIL sb_inv got %h exp %h", smpi, ei);
    end
  endtask

  task automatic test_reset();
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);
    checks++;
    if ({hs, vs, de, hx, vy, ls, fs} !== {3'b110, 22'd0, 2'b00}) begin
      errors++;
      $display("FAIL reset_vals got %b", {hs, vs, de, hx, vy, ls, fs});
    end
    checks++;
    if ({ihs, ivs, bhs, bvs} !== 4'b0011) begin
      errors++;
      $display("FAIL reset_pol got %b exp 0011", {ihs, ivs, bhs, bvs});
    end
  endtask

  task automatic test_frame();
    int n_hs = 0, n_vs = 0, n_de = 0, n_ls = 0, n_fs = 0;
    int n_ihs = 0, n_ivs = 0, n_ide = 0;
    int mx = 0, my = 0, falls = 0, k_hs = -1, k_de = -1;
    logic [21:0] de_xy = '1;
    logic p_hs = 1'b1;
    cyc(1'b1, 1'b1);
    for (int k = 1; k <= FR; k++) begin
      cyc(1'b0, 1'b1);
      n_hs += int'(!hs);
      n_vs += int'(!vs);
      n_de += int'(de);
      n_ls += int'(ls);
      n_fs += int'(fs);
      n_ihs += int'(ihs);
      n_ivs += int'(ivs);
      n_ide += int'(ide);
      if (int'(hx) > mx) mx = int'(hx);
      if (int'(vy) > my) my = int'(vy);
      if (p_hs && !hs) begin
        falls++;
        if (falls == VS + VB + 1) k_hs = k;
      end
      p_hs = hs;
      if (de && k_de < 0) begin
        k_de  = k;
        de_xy = {hx, vy};
      end
    end
    checks++;
    if (n_hs != HS * VT) begin
      errors++; $display("FAIL hs_low got %0d exp %0d", n_hs, HS * VT);
    end
    checks++;
    if (n_vs != VS * HT) begin
      errors++; $display("FAIL vs_low got %0d exp %0d", n_vs, VS * HT);
    end
    checks++;
    if (n_de != HA * VA) begin
      errors++; $display("FAIL de_count got %0d exp %0d", n_de, HA * VA);
    end
    checks++;
    if (n_ls != VT || n_fs != 1) begin
      errors++; $display("FAIL strobes got ls %0d fs %0d exp %0d 1",
                         n_ls, n_fs, VT);
    end
    checks++;
    if (mx != HA - 1 || my != VA - 1) begin
      errors++; $display("FAIL coord_max got %0d,%0d exp %0d,%0d",
                         mx, my, HA - 1, VA - 1);
    end
    checks++;
    if (k_de != 1 + HT * (VS + VB) + HS + HB || k_de - k_hs != HS + HB) begin
      errors++; $display("FAIL first_de got k %0d hs %0d exp k %0d",
                         k_de, k_hs, 1 + HT * (VS + VB) + HS + HB);
    end
    checks++;
    if (de_xy !== 22'd0) begin
      errors++; $display("FAIL first_de_xy got %h exp 0", de_xy);
    end
    checks++;
    if (n_ihs != HS * VT || n_ivs != VS * HT || n_ide != HA * VA) begin
      errors++; $display("FAIL inv_counts got %0d %0d %0d",
                         n_ihs, n_ivs, n_ide);
    end
  endtask

  task automatic test_ce_toggle();
    int n_ls = 0, n_fs = 0, f0 = -1, f1 = -1, dbl = 0, hold = 0;
    exp_t prev;
    cyc(1'b1, 1'b1);
    prev = smp;
    for (int i = 1; i <= 4 * FR; i++) begin
      cyc(1'b0, (i % 2) == 1);
      if ((i % 2) == 0) begin
        if (smp[26:2] !== prev[26:2] || smp[1:0] !== 2'b00) hold++;
      end
      if ((ls && prev.ls) || (fs && prev.fs)) dbl++;
      n_ls += int'(ls);
      if (fs) begin
        n_fs++;
        if (f0 < 0) f0 = i;
        else if (f1 < 0) f1 = i;
      end
      prev = smp;
    end
    checks++;
    if (n_fs != 2 || f1 - f0 != 2 * FR) begin
      errors++; $display("FAIL ce_fs_period got %0d n %0d exp %0d n 2",
                         f1 - f0, n_fs, 2 * FR);
    end
    checks++;
    if (n_ls != 2 * VT) begin
      errors++; $display("FAIL ce_ls got %0d exp %0d", n_ls, 2 * VT);
    end
    checks++;
    if (dbl != 0) begin
      errors++; $display("FAIL strobe_width got %0d exp 0", dbl);
    end
    checks++;
    if (hold != 0) begin
      errors++; $display("FAIL ce0_hold got %0d exp 0", hold);
    end
  endtask

  task automatic test_mid_reset();
    logic was_de;
    cyc(1'b1, 1'b1);
    for (int i = 0; i < FR; i++) begin
      if (m_hc == 12 && m_vc == 6) break;
      cyc(1'b0, 1'b1);
    end
    cyc(1'b0, 1'b1);
    was_de = de;
    cyc(1'b1, 1'b1);
    checks++;
    if (!was_de || {hs, vs, de, hx, vy, ls, fs} !== {3'b110, 22'd0, 2'b00})
    begin
      errors++; $display("FAIL mid_reset got de_before %b out %b",
                         was_de, {hs, vs, de, hx, vy, ls, fs});
    end
    cyc(1'b0, 1'b1);
    checks++;
    if ({fs, ls, hs, vs, de} !== 5'b11000) begin
      errors++; $display("FAIL after_reset got %b exp 11000",
                         {fs, ls, hs, vs, de});
    end
  endtask

  task automatic test_640();
    int n_hs = 0, n_vs = 0, n_de = 0, n_ls = 0, n_fs = 0;
    cyc(1'b1, 1'b1);
    for (int i = 0; i < 1600; i++) begin
      cyc(1'b0, 1'b1);
      n_hs += int'(!bhs);
      n_vs += int'(!bvs);
      n_de += int'(bde);
      n_ls += int'(bls);
      n_fs += int'(bfs);
    end
    checks++;
    if (n_hs != 192 || n_vs != 1600) begin
      errors++; $display("FAIL m640_sync got hs %0d vs %0d exp 192 1600",
                         n_hs, n_vs);
    end
    checks++;
    if (n_ls != 2 || n_fs != 1 || n_de != 0) begin
      errors++; $display("FAIL m640_strobe got ls %0d fs %0d de %0d",
                         n_ls, n_fs, n_de);
    end
  endtask

  initial begin
    m_out = '{hs: 1'b1, vs: 1'b1, de: 1'b0, x: '0, y: '0,
              ls: 1'b0, fs: 1'b0};
    test_reset();
    test_frame();
    test_ce_toggle();
    test_mid_reset();
    test_640();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
